panda_risc_v_mul_share_arbiter: RTL and testbench

- Shares the single multi-cycle multiplier between two requesters.
  - Requester 0 is the main ALU/EXU issue path.
  - Requester 1 is a secondary issue path, e.g. the address-gen/CSR helper.
- Arbitrates requests round-robin onto the multiplier request channel.
- Records each accepted grantee in an in-order order FIFO.
- Routes each multiplier result back to the requester that issued it. The multiplier returns results strictly in issue order.
- Sits between the EXU issue logic and the multiplier.

---
 rtl/panda_risc_v_mul_share_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_panda_risc_v_mul_share_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_risc_v_mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// panda_risc_v_mul_share_arbiter
//
// Shares one multi-cycle multiplier between two requesters:
//   requester 0 : main ALU/EXU issue path
//   requester 1 : secondary issue path (address-gen / CSR helper)
//
// Requests are arbitrated round-robin onto the multiplier request channel.
// Each accepted grant index is pushed into a small in-order FIFO. Because
// the multiplier returns results strictly in issue order, the FIFO head
// names the requester that owns the next result.
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1. A granted valid is held until accepted;
// the arbiter locks its grant while the multiplier stalls so the payload it
// presents stays stable.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   s0_req_* / s1_req_*    request channels from the two requesters
//   m_mul_req_*            request channel to the multiplier
//   s_mul_res_*            result channel from the multiplier
//   m0_res_* / m1_res_*    result channels back to the two requesters
//   outstanding_cnt        requests accepted but not yet returned
//   err_orphan_res         sticky: a result arrived with nothing in flight
// ---------------------------------------------------------------------------
module panda_risc_v_mul_share_arbiter #(
    parameter int  inst_id_width    = 4,
    parameter int  outstanding_max  = 4,
    parameter real simulation_delay = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [32:0]              s0_req_op_a,
    input  logic [32:0]              s0_req_op_b,
    input  logic                     s0_req_res_sel,
    input  logic [4:0]               s0_req_rd_id,
    input  logic [inst_id_width-1:0] s0_req_inst_id,
    input  logic                     s0_req_valid,
    output logic                     s0_req_ready,
    input  logic [32:0]              s1_req_op_a,
    input  logic [32:0]              s1_req_op_b,
    input  logic                     s1_req_res_sel,
    input  logic [4:0]               s1_req_rd_id,
    input  logic [inst_id_width-1:0] s1_req_inst_id,
    input  logic                     s1_req_valid,
    output logic                     s1_req_ready,
    output logic [32:0]              m_mul_req_op_a,
    output logic [32:0]              m_mul_req_op_b,
    output logic                     m_mul_req_res_sel,
    output logic [4:0]               m_mul_req_rd_id,
    output logic [inst_id_width-1:0] m_mul_req_inst_id,
    output logic                     m_mul_req_valid,
    input  logic                     m_mul_req_ready,
    input  logic [31:0]              s_mul_res_data,
    input  logic [4:0]               s_mul_res_rd_id,
    input  logic [inst_id_width-1:0] s_mul_res_inst_id,
    input  logic                     s_mul_res_valid,
    output logic                     s_mul_res_ready,
    output logic [31:0]              m0_res_data,
    output logic [4:0]               m0_res_rd_id,
    output logic [inst_id_width-1:0] m0_res_inst_id,
    output logic                     m0_res_valid,
    input  logic                     m0_res_ready,
    output logic [31:0]              m1_res_data,
    output logic [4:0]               m1_res_rd_id,
    output logic [inst_id_width-1:0] m1_res_inst_id,
    output logic                     m1_res_valid,
    input  logic                     m1_res_ready,
    output logic [3:0]               outstanding_cnt,
    output logic                     err_orphan_res
);

    // simulation_delay is kept for interface compatibility with the rest of
    // the core; register updates here are plain non-blocking assignments.
    generate
        if (outstanding_max < 1 || outstanding_max > 8 || simulation_delay < 0.0) begin : g_bad_param
            $error("panda_risc_v_mul_share_arbiter: parameter out of range");
        end
    endgenerate

    localparam logic [3:0] depth_cnt = 4'(outstanding_max);
    localparam logic [2:0] last_ptr  = 3'(outstanding_max - 1);

    // arbitration state
    logic last_grant;
    logic lock;
    logic lock_idx;

    // order FIFO: one bit per entry naming the requester; sized for the
    // largest depth, only entries 0..outstanding_max-1 are ever addressed
    logic [7:0] order_q;
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] count;
    logic       err_q;

    logic grant_vld;
    logic grant_idx;
    logic fifo_not_full;
    logic fifo_not_empty;
    logic head;
    logic req_fire;
    logic res_fire;
    logic orphan;

    // grant selection
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (lock) begin
            grant_idx = lock_idx;
            grant_vld = lock_idx ? s1_req_valid : s0_req_valid;
        end else if (s0_req_valid && s1_req_valid) begin
            grant_vld = 1'b1;
            grant_idx = ~last_grant;
        end else if (s0_req_valid) begin
            grant_vld = 1'b1;
            grant_idx = 1'b0;
        end else if (s1_req_valid) begin
            grant_vld = 1'b1;
            grant_idx = 1'b1;
        end
    end

    // full is judged on the registered count, so a same-cycle pop never
    // frees a slot for a push until the following cycle
    assign fifo_not_full  = (count != depth_cnt);
    assign fifo_not_empty = (count != 4'd0);

    // request path: pure mux of the granted requester
    assign m_mul_req_op_a    = grant_idx ? s1_req_op_a    : s0_req_op_a;
    assign m_mul_req_op_b    = grant_idx ? s1_req_op_b    : s0_req_op_b;
    assign m_mul_req_res_sel = grant_idx ? s1_req_res_sel : s0_req_res_sel;
    assign m_mul_req_rd_id   = grant_idx ? s1_req_rd_id   : s0_req_rd_id;
    assign m_mul_req_inst_id = grant_idx ? s1_req_inst_id : s0_req_inst_id;
    assign m_mul_req_valid   = ~rst & grant_vld & fifo_not_full;

    assign s0_req_ready = ~rst & grant_vld & ~grant_idx & m_mul_req_ready & fifo_not_full;
    assign s1_req_ready = ~rst & grant_vld &  grant_idx & m_mul_req_ready & fifo_not_full;

    assign req_fire = m_mul_req_valid & m_mul_req_ready;

    // result path: the FIFO head selects the destination
    assign head = order_q[rd_ptr];

    assign m0_res_data    = s_mul_res_data;
    assign m0_res_rd_id   = s_mul_res_rd_id;
    assign m0_res_inst_id = s_mul_res_inst_id;
    assign m1_res_data    = s_mul_res_data;
    assign m1_res_rd_id   = s_mul_res_rd_id;
    assign m1_res_inst_id = s_mul_res_inst_id;

    assign m0_res_valid = ~rst & s_mul_res_valid & fifo_not_empty & ~head;
    assign m1_res_valid = ~rst & s_mul_res_valid & fifo_not_empty &  head;

    // with nothing in flight the result is swallowed so the multiplier
    // cannot wedge; the error flag records that it happened
    assign s_mul_res_ready = ~rst & (fifo_not_empty ? (head ? m1_res_ready : m0_res_ready) : 1'b1);

    assign res_fire = s_mul_res_valid & s_mul_res_ready & fifo_not_empty;
    assign orphan   = s_mul_res_valid & ~fifo_not_empty;

    // arbitration state: last winner and grant lock while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            lock       <= 1'b0;
            lock_idx   <= 1'b0;
        end else if (req_fire) begin
            last_grant <= grant_idx;
            lock       <= 1'b0;
        end else if (m_mul_req_valid) begin
            lock       <= 1'b1;
            lock_idx   <= grant_idx;
        end
    end

    // order FIFO and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order_q <= 8'd0;
            wr_ptr  <= 3'd0;
            rd_ptr  <= 3'd0;
            count   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            if (req_fire) begin
                order_q[wr_ptr] <= grant_idx;
                wr_ptr          <= (wr_ptr == last_ptr) ? 3'd0 : wr_ptr + 3'd1;
            end
            if (res_fire) begin
                rd_ptr <= (rd_ptr == last_ptr) ? 3'd0 : rd_ptr + 3'd1;
            end
            case ({req_fire, res_fire})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (orphan) begin
                err_q <= 1'b1;
            end
        end
    end

    assign outstanding_cnt = count;
    assign err_orphan_res  = err_q;

endmodule

// File: tb/tb_panda_risc_v_mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for panda_risc_v_mul_share_arbiter (order FIFO depth 2).
// The bench plays the multiplier: it captures accepted requests, computes
// the signed product and returns results in order. Expected results are
// pushed to exp_q when stimulus is driven and popped when a routed result
// handshakes on m0/m1.
// ---------------------------------------------------------------------------
module tb_panda_risc_v_mul_share_arbiter;

    localparam int IW    = 4;
    localparam int DEPTH = 2;

    logic          clk;
    logic          rst;
    logic [32:0]   s0_req_op_a, s0_req_op_b, s1_req_op_a, s1_req_op_b;
    logic          s0_req_res_sel, s1_req_res_sel;
    logic [4:0]    s0_req_rd_id, s1_req_rd_id;
    logic [IW-1:0] s0_req_inst_id, s1_req_inst_id;
    logic          s0_req_valid, s1_req_valid;
    logic          s0_req_ready, s1_req_ready;
    logic [32:0]   m_mul_req_op_a, m_mul_req_op_b;
    logic          m_mul_req_res_sel;
    logic [4:0]    m_mul_req_rd_id;
    logic [IW-1:0] m_mul_req_inst_id;
    logic          m_mul_req_valid, m_mul_req_ready;
    logic [31:0]   s_mul_res_data;
    logic [4:0]    s_mul_res_rd_id;
    logic [IW-1:0] s_mul_res_inst_id;
    logic          s_mul_res_valid, s_mul_res_ready;
    logic [31:0]   m0_res_data, m1_res_data;
    logic [4:0]    m0_res_rd_id, m1_res_rd_id;
    logic [IW-1:0] m0_res_inst_id, m1_res_inst_id;
    logic          m0_res_valid, m1_res_valid;
    logic          m0_res_ready, m1_res_ready;
    logic [3:0]    outstanding_cnt;
    logic          err_orphan_res;

    panda_risc_v_mul_share_arbiter #(
        .inst_id_width   (IW),
        .outstanding_max (DEPTH),
        .simulation_delay(1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s0_req_op_a      (s0_req_op_a),
        .s0_req_op_b      (s0_req_op_b),
        .s0_req_res_sel   (s0_req_res_sel),
        .s0_req_rd_id     (s0_req_rd_id),
        .s0_req_inst_id   (s0_req_inst_id),
        .s0_req_valid     (s0_req_valid),
        .s0_req_ready     (s0_req_ready),
        .s1_req_op_a      (s1_req_op_a),
        .s1_req_op_b      (s1_req_op_b),
        .s1_req_res_sel   (s1_req_res_sel),
        .s1_req_rd_id     (s1_req_rd_id),
        .s1_req_inst_id   (s1_req_inst_id),
        .s1_req_valid     (s1_req_valid),
        .s1_req_ready     (s1_req_ready),
        .m_mul_req_op_a   (m_mul_req_op_a),
        .m_mul_req_op_b   (m_mul_req_op_b),
        .m_mul_req_res_sel(m_mul_req_res_sel),
        .m_mul_req_rd_id  (m_mul_req_rd_id),
        .m_mul_req_inst_id(m_mul_req_inst_id),
        .m_mul_req_valid  (m_mul_req_valid),
        .m_mul_req_ready  (m_mul_req_ready),
        .s_mul_res_data   (s_mul_res_data),
        .s_mul_res_rd_id  (s_mul_res_rd_id),
        .s_mul_res_inst_id(s_mul_res_inst_id),
        .s_mul_res_valid  (s_mul_res_valid),
        .s_mul_res_ready  (s_mul_res_ready),
        .m0_res_data      (m0_res_data),
        .m0_res_rd_id     (m0_res_rd_id),
        .m0_res_inst_id   (m0_res_inst_id),
        .m0_res_valid     (m0_res_valid),
        .m0_res_ready     (m0_res_ready),
        .m1_res_data      (m1_res_data),
        .m1_res_rd_id     (m1_res_rd_id),
        .m1_res_inst_id   (m1_res_inst_id),
        .m1_res_valid     (m1_res_valid),
        .m1_res_ready     (m1_res_ready),
        .outstanding_cnt  (outstanding_cnt),
        .err_orphan_res   (err_orphan_res)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [40:0] mul_q[$];   // {data, rd, inst} pending in the multiplier model
    logic [41:0] exp_q[$];   // {requester, data, rd, inst} expected on m0/m1
    logic        ret_en = 1'b0;
    logic        orph   = 1'b0;

    logic [32:0]   pa[2];
    logic [32:0]   pb[2];
    logic          ps[2];
    logic [4:0]    prd[2];
    logic [IW-1:0] pid[2];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mul_res(input logic [32:0] a, input logic [32:0] b, input logic sel);
        logic signed [65:0] p;
        p = $signed(a) * $signed(b);
        return sel ? p[63:32] : p[31:0];
    endfunction

    task automatic push_exp(input logic idx, input logic [31:0] d, input logic [4:0] rd, input logic [IW-1:0] id);
        exp_q.push_back({idx, d, rd, id});
    endtask

    task automatic push_exp_p(input int r);
        push_exp(r[0], mul_res(pa[r], pb[r], ps[r]), prd[r], pid[r]);
    endtask

    task automatic check_res(input string tag, input logic idx, input logic [31:0] d,
                             input logic [4:0] rd, input logic [IW-1:0] id);
        logic [41:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {22'd0, idx, d, rd, id}, {22'd0, e});
        end
    endtask

    // ---------------- multiplier model + result monitor ----------------
    // sampled on the falling edge, mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            mul_q.delete();
        end else begin
            if (s_mul_res_valid && s_mul_res_ready && !orph && mul_q.size() > 0)
                void'(mul_q.pop_front());
            if (m_mul_req_valid && m_mul_req_ready)
                mul_q.push_back({mul_res(m_mul_req_op_a, m_mul_req_op_b, m_mul_req_res_sel),
                                 m_mul_req_rd_id, m_mul_req_inst_id});
            if (m0_res_valid && m1_res_valid)
                chk("res_both_valid", 64'd1, 64'd0);
            if (m0_res_valid && m0_res_ready)
                check_res("res_m0", 1'b0, m0_res_data, m0_res_rd_id, m0_res_inst_id);
            if (m1_res_valid && m1_res_ready)
                check_res("res_m1", 1'b1, m1_res_data, m1_res_rd_id, m1_res_inst_id);
        end
    end

    // result driver: presents the oldest pending product, or a stray result
    initial begin
        s_mul_res_valid   = 1'b0;
        s_mul_res_data    = '0;
        s_mul_res_rd_id   = '0;
        s_mul_res_inst_id = '0;
        forever begin
            @(posedge clk);
            #2;
            if (orph) begin
                s_mul_res_valid   = 1'b1;
                s_mul_res_data    = 32'hDEAD_BEEF;
                s_mul_res_rd_id   = 5'd31;
                s_mul_res_inst_id = '1;
            end else if (ret_en && mul_q.size() > 0) begin
                s_mul_res_valid = 1'b1;
                {s_mul_res_data, s_mul_res_rd_id, s_mul_res_inst_id} = mul_q[0];
            end else begin
                s_mul_res_valid = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_payload();
        s0_req_op_a = pa[0]; s0_req_op_b = pb[0]; s0_req_res_sel = ps[0];
        s0_req_rd_id = prd[0]; s0_req_inst_id = pid[0];
        s1_req_op_a = pa[1]; s1_req_op_b = pb[1]; s1_req_res_sel = ps[1];
        s1_req_rd_id = prd[1]; s1_req_inst_id = pid[1];
    endtask

    task automatic new_payload(input int r);
        int va;
        int vb;
        va = int'($urandom_range(0, 200000)) - 100000;
        vb = int'($urandom_range(0, 200000)) - 100000;
        pa[r]  = {va[31], va};
        pb[r]  = {vb[31], vb};
        ps[r]  = 1'($urandom_range(0, 1));
        prd[r] = 5'($urandom_range(0, 31));
        pid[r] = IW'($urandom_range(0, (1 << IW) - 1));
        apply_payload();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        step();
        ret_en = 1'b0;
        orph   = 1'b0;
        rst    = 1'b1;
        #3;
        chk("rst_cnt", 64'(outstanding_cnt), 64'd0);
        chk("rst_err", 64'(err_orphan_res), 64'd0);
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        s0_req_valid = 1'b0;
        s1_req_valid = 1'b0;
        m_mul_req_ready = 1'b1;
        m0_res_ready = 1'b1;
        m1_res_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            pa[r] = '0; pb[r] = '0; ps[r] = 1'b0; prd[r] = '0; pid[r] = '0;
        end
        apply_payload();

        // outputs held low while reset is asserted
        repeat (2) @(posedge clk);
        #1;
        s0_req_valid = 1'b1;
        #3;
        chk("rst_s0_ready", 64'(s0_req_ready), 64'd0);
        chk("rst_mreq_valid", 64'(m_mul_req_valid), 64'd0);
        chk("rst_res_ready", 64'(s_mul_res_ready), 64'd0);
        step();
        s0_req_valid = 1'b0;
        rst = 1'b0;
        #3;
        chk("init_cnt", 64'(outstanding_cnt), 64'd0);
        chk("init_err", 64'(err_orphan_res), 64'd0);
        chk("init_mreq_valid", 64'(m_mul_req_valid), 64'd0);

        // single requester: 3 * -5, low word
        ret_en = 1'b1;
        step();
        pa[0] = 33'd3; pb[0] = -33'sd5; ps[0] = 1'b0; prd[0] = 5'd7; pid[0] = 4'd2;
        apply_payload();
        s0_req_valid = 1'b1;
        #3;
        chk("single_mreq_valid", 64'(m_mul_req_valid), 64'd1);
        chk("single_op_a", 64'(m_mul_req_op_a), 64'd3);
        chk("single_op_b", 64'(m_mul_req_op_b), 64'h1_FFFF_FFFB);
        chk("single_inst", 64'(m_mul_req_inst_id), 64'd2);
        chk("single_s0_ready", 64'(s0_req_ready), 64'd1);
        chk("single_s1_ready", 64'(s1_req_ready), 64'd0);
        push_exp(1'b0, 32'hFFFF_FFF1, 5'd7, 4'd2);
        step();
        s0_req_valid = 1'b0;
        wait_drain(20);

        // contention after reset: 0,1,0,1
        do_reset();
        ret_en = 1'b1;
        new_payload(0);
        new_payload(1);
        s0_req_valid = 1'b1;
        s1_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                step();
                new_payload((k - 1) % 2);
            end
            #3;
            chk($sformatf("rr_s0_ready_%0d", k), 64'(s0_req_ready), 64'((k % 2) == 0));
            chk($sformatf("rr_s1_ready_%0d", k), 64'(s1_req_ready), 64'((k % 2) == 1));
            push_exp_p(k % 2);
        end
        step();
        s0_req_valid = 1'b0;
        s1_req_valid = 1'b0;
        wait_drain(40);

        // grant lock: s1 stalled 3 cycles, s0 arrives in cycle 2
        step();
        m_mul_req_ready = 1'b0;
        new_payload(1);
        s1_req_valid = 1'b1;
        #3;
        chk("lock_op_a_0", 64'(m_mul_req_op_a), 64'(pa[1]));
        chk("lock_s1_ready_0", 64'(s1_req_ready), 64'd0);
        for (int c = 1; c < 3; c++) begin
            step();
            if (c == 1) begin
                new_payload(0);
                s0_req_valid = 1'b1;
            end
            #3;
            chk($sformatf("lock_op_a_%0d", c), 64'(m_mul_req_op_a), 64'(pa[1]));
            chk($sformatf("lock_rd_%0d", c), 64'(m_mul_req_rd_id), 64'(prd[1]));
            chk($sformatf("lock_s0_ready_%0d", c), 64'(s0_req_ready), 64'd0);
        end
        step();
        m_mul_req_ready = 1'b1;
        #3;
        chk("lock_release_s1", 64'(s1_req_ready), 64'd1);
        chk("lock_release_s0", 64'(s0_req_ready), 64'd0);
        chk("lock_release_op_a", 64'(m_mul_req_op_a), 64'(pa[1]));
        push_exp_p(1);
        step();
        s1_req_valid = 1'b0;
        #3;
        chk("lock_next_s0", 64'(s0_req_ready), 64'd1);
        push_exp_p(0);
        step();
        s0_req_valid = 1'b0;
        wait_drain(40);

        // FIFO full at depth 2, pop does not free the slot the same cycle
        ret_en = 1'b0;
        for (int n = 0; n < 2; n++) begin
            step();
            new_payload(0);
            s0_req_valid = 1'b1;
            #3;
            chk($sformatf("full_fill_%0d", n), 64'(s0_req_ready), 64'd1);
            push_exp_p(0);
        end
        step();
        new_payload(0);
        #3;
        chk("full_s0_ready", 64'(s0_req_ready), 64'd0);
        chk("full_mreq_valid", 64'(m_mul_req_valid), 64'd0);
        chk("full_cnt", 64'(outstanding_cnt), 64'd2);
        step();
        ret_en = 1'b1;
        #3;
        chk("full_pop_s0_ready", 64'(s0_req_ready), 64'd0);
        step();
        ret_en = 1'b0;
        #3;
        chk("full_resume_s0_ready", 64'(s0_req_ready), 64'd1);
        chk("full_resume_cnt", 64'(outstanding_cnt), 64'd1);
        push_exp_p(0);
        step();
        s0_req_valid = 1'b0;
        ret_en = 1'b1;
        wait_drain(40);

        // result backpressure on requester 1
        step();
        m1_res_ready = 1'b0;
        new_payload(1);
        s1_req_valid = 1'b1;
        #3;
        chk("bp_s1_ready", 64'(s1_req_ready), 64'd1);
        push_exp_p(1);
        for (int c = 0; c < 4; c++) begin
            step();
            if (c == 0) s1_req_valid = 1'b0;
            #3;
            chk($sformatf("bp_res_ready_%0d", c), 64'(s_mul_res_ready), 64'd0);
            chk($sformatf("bp_m1_valid_%0d", c), 64'(m1_res_valid), 64'd1);
            chk($sformatf("bp_m0_valid_%0d", c), 64'(m0_res_valid), 64'd0);
            chk($sformatf("bp_cnt_%0d", c), 64'(outstanding_cnt), 64'd1);
        end
        step();
        m1_res_ready = 1'b1;
        wait_drain(40);

        // orphan result with empty FIFO
        ret_en = 1'b0;
        step();
        orph = 1'b1;
        #3;
        chk("orphan_res_ready", 64'(s_mul_res_ready), 64'd1);
        chk("orphan_m0_valid", 64'(m0_res_valid), 64'd0);
        chk("orphan_m1_valid", 64'(m1_res_valid), 64'd0);
        step();
        orph = 1'b0;
        #3;
        chk("orphan_err", 64'(err_orphan_res), 64'd1);

        // reset with two requests outstanding
        for (int n = 0; n < 2; n++) begin
            step();
            new_payload(0);
            s0_req_valid = 1'b1;
        end
        step();
        s0_req_valid = 1'b0;
        #3;
        chk("pre_rst_cnt", 64'(outstanding_cnt), 64'd2);
        chk("pre_rst_err", 64'(err_orphan_res), 64'd1);
        do_reset();
        new_payload(0);
        new_payload(1);
        s0_req_valid = 1'b1;
        s1_req_valid = 1'b1;
        #3;
        chk("post_rst_s0_wins", 64'(s0_req_ready), 64'd1);
        chk("post_rst_s1_waits", 64'(s1_req_ready), 64'd0);
        push_exp_p(0);
        step();
        s0_req_valid = 1'b0;
        #3;
        chk("post_rst_s1_next", 64'(s1_req_ready), 64'd1);
        push_exp_p(1);
        step();
        s1_req_valid = 1'b0;
        ret_en = 1'b1;
        wait_drain(40);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
